// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter.
//   state_e      arbiter FSM states (IDLE/ACCESS/WAIT/RESP)
//   MODE_READ    value of mem.mode that reads (and never writes)
//   MODE_WRITE   value of mem.mode that commits data_in at the clock edge
//   REQ_R0/R1    requester indices into the 2-bit request/response vectors
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

    localparam int REQ_R0 = 0;
    localparam int REQ_R1 = 1;

    // Index of the single set bit of a two-requester grant vector.
    function automatic logic grant_idx(input logic [1:0] grant);
        return grant[REQ_R1];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between the two requesters.
//   req_valid  in   2  request pending per requester
//   last_grant in   1  requester that won the previous handshake
//   grant      out  2  one-hot winner, all zero when nobody is requesting
// Macro MEM_ARB_RR_EN selects round-robin on ties; without it r0 always wins
// ties and last_grant is ignored.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            // Tie: the requester that did not win last time goes next.
            grant = (last_grant == 1'(REQ_R1)) ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 2'b00;
        if (req_valid[REQ_R0]) begin
            grant = 2'b01;
        end else if (req_valid[REQ_R1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two requesters, one
// transaction in flight at a time.
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata   per-requester request channel
//   resp_valid     one-cycle completion pulse per requester
//   resp_rdata     read data (shared), valid with resp_valid, held otherwise
//   mem_addr/mem_data_in/mem_mode/mem_data_out   memory port (mode 1=read)
//   dbg_state      current FSM state, for observation only
// Handshake: a request is taken in the cycle where req_valid[i] & req_ready[i]
// are both high. req_ready is only ever raised in IDLE, for the single winner,
// so a requester may withdraw valid at any time without losing anything.
// Tie resolution is set by MEM_ARB_RR_EN inside mem_arb_pick.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data_in,
    output logic            mem_mode,
    input  logic [DW-1:0]   mem_data_out,
    output logic [1:0]      dbg_state
);

    // Reload value for the read-latency counter; WAIT ends when it hits 0.
    localparam logic [1:0] LAT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_e          state_q, state_d;
    logic [1:0]      lat_cnt_q, lat_cnt_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      grant;
    logic            sel;

    mem_arb_pick u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign sel = grant_idx(grant);

    // State register and datapath latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_cnt_q    <= 2'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state and latch updates.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                // grant is non-zero only for a valid requester, and in IDLE
                // req_ready equals grant, so this is exactly the handshake.
                if (|grant) begin
                    owner_d      = sel;
                    last_grant_d = sel;
                    we_d         = sel ? req_we[REQ_R1] : req_we[REQ_R0];
                    addr_d       = sel ? req_addr[REQ_R1*AW +: AW]
                                       : req_addr[REQ_R0*AW +: AW];
                    wdata_d      = sel ? req_wdata[REQ_R1*DW +: DW]
                                       : req_wdata[REQ_R0*DW +: DW];
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else if (RD_LAT == 0) begin
                    rdata_d = mem_data_out;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    rdata_d = mem_data_out;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. mem_mode is forced to read everywhere except ACCESS so the
    // memory can never see a write outside the one intended cycle.
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        mem_mode   = MODE_READ;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so nothing looks accepted while reset is held.
                if (rst_n) begin
                    req_ready = grant;
                end
            end
            ACCESS: begin
                mem_mode = we_q ? MODE_WRITE : MODE_READ;
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign resp_rdata  = rdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter
// driving a behavioural 256x32 memory with one cycle of read latency.
// Every cycle the bench predicts req_ready, resp_valid, resp_rdata and the
// memory port from a transaction-level model: a model memory array and a
// queue of outstanding responses with their due cycles.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_in;
    logic            mem_mode;
    logic [DW-1:0]   mem_data_out;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_mode     (mem_mode),
        .mem_data_out (mem_data_out),
        .dbg_state    (dbg_state)
    );

    // Behavioural single-port memory: registered read, write on mode=0.
    logic [DW-1:0] mem_arr [256];
    logic          mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= DW'(i * 3 + 1);
        end else begin
            if (mem_mode == MODE_WRITE) mem_arr[mem_addr] <= mem_data_in;
            mem_data_out <= mem_arr[mem_addr];
        end
    end

    // Reference model state.
    typedef struct {
        int            due;
        logic          owner;
        logic          is_rd;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          exp_q[$];
    logic [DW-1:0] ref_mem [256];
    logic          ref_last;
    logic [DW-1:0] ref_rdata;
    logic [AW-1:0] ref_addr;
    logic [DW-1:0] ref_wdata;
    int            wr_cycle;
    int            cyc;
    int            checks;
    int            errors;
    int            grants [2];
    int            resp_cnt [2];
    int            last_hs [2];
    int            last_resp [2];
    int            grant_seq[$];
    logic [1:0]    hs_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_winner(input logic [1:0] v, input logic last);
        if (v == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            return last ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ref_last  = 1'b1;
        ref_rdata = '0;
        ref_addr  = '0;
        ref_wdata = '0;
        wr_cycle  = -1;
    endtask

    // One clock cycle: check at the falling edge, advance model, then step.
    task automatic cycle_step();
        logic [1:0] exp_ready;
        logic [1:0] exp_resp;
        logic       idle;
        int         w;
        @(negedge clk);
        chk("mem_addr", 32'(mem_addr), 32'(ref_addr));
        chk("mem_data_in", mem_data_in, ref_wdata);
        chk("mem_mode", 32'(mem_mode), (cyc == wr_cycle) ? 32'd0 : 32'd1);
        idle = (exp_q.size() == 0);
        exp_resp = 2'b00;
        if (!idle && exp_q[0].due == cyc) begin
            exp_resp[exp_q[0].owner] = 1'b1;
            if (exp_q[0].is_rd) ref_rdata = exp_q[0].data;
            exp_q.delete(0);
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_resp));
        chk("resp_rdata", resp_rdata, ref_rdata);
        for (int i = 0; i < 2; i++) begin
            if (resp_valid[i]) begin
                resp_cnt[i]++;
                last_resp[i] = cyc;
            end
        end
        exp_ready = (rst_n && idle) ? ref_winner(req_valid, ref_last) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        hs_obs = req_valid & req_ready;
        for (int i = 0; i < 2; i++) begin
            if (hs_obs[i]) begin
                last_hs[i] = cyc;
                grant_seq.push_back(i);
            end
        end
        if (|exp_ready) begin
            txn_t t;
            w = exp_ready[1] ? 1 : 0;
            t.owner = exp_ready[1];
            t.is_rd = !req_we[w];
            t.due   = cyc + (req_we[w] ? 2 : 2 + RD_LAT);
            ref_addr  = req_addr[w*AW +: AW];
            ref_wdata = req_wdata[w*DW +: DW];
            t.data  = ref_mem[ref_addr];
            if (req_we[w]) begin
                ref_mem[ref_addr] = ref_wdata;
                wr_cycle = cyc + 1;
            end
            exp_q.push_back(t);
            ref_last = exp_ready[1];
            grants[w]++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int r, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid[r] = 1'b1;
        req_we[r]    = we;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = d;
        do begin
            cycle_step();
            n++;
        end while (!hs_obs[r] && n < 40);
        req_valid[r] = 1'b0;
        chk("issue_handshake", 32'(hs_obs[r]), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            cycle_step();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic mem_compare(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0_before;
        int r1_before;
        int hs1_before;
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < 2; i++) begin
            grants[i] = 0; resp_cnt[i] = 0; last_hs[i] = -1; last_resp[i] = -1;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i * 3 + 1);
        model_reset();
        hs_obs    = 2'b00;
        rst_n     = 1'b0;
        mem_load  = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state, with both requesters pushing: nothing may be accepted.
        #1;
        repeat (3) cycle_step();
        mem_load = 1'b0;
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        req_valid = 2'b00;
        rst_n = 1'b1;
        cycle_step();

        // 1: r1 write then read back, with explicit latency checks.
        issue(1, 1'b1, 8'd2, 32'd30);
        drain();
        chk("t1_wr_latency", 32'(last_resp[1] - last_hs[1]), 32'd2);
        issue(1, 1'b0, 8'd2, 32'd0);
        drain();
        chk("t1_rd_latency", 32'(last_resp[1] - last_hs[1]), 32'(2 + RD_LAT));
        chk("t1_rdata", resp_rdata, 32'd30);

        // 2: both requesters read continuously.
        cycle_step();
        grant_seq.delete();
        req_we    = 2'b00;
        req_addr  = {8'd5, 8'd4};
        req_valid = 2'b11;
        repeat (16) cycle_step();
        req_valid = 2'b00;
        drain();
        chk("t2_grant_count", 32'(grant_seq.size() >= 4), 32'd1);
`ifdef MEM_ARB_RR_EN
        chk("t2_grant0", 32'(grant_seq[0]), 32'd0);
        chk("t2_grant1", 32'(grant_seq[1]), 32'd1);
        chk("t2_grant2", 32'(grant_seq[2]), 32'd0);
        chk("t2_grant3", 32'(grant_seq[3]), 32'd1);
`else
        for (int i = 0; i < 4; i++) chk("t2_grant_fixed", 32'(grant_seq[i]), 32'd0);
`endif

        // 3: ten idle cycles, memory must be untouched.
        r0_before = resp_cnt[0];
        r1_before = resp_cnt[1];
        repeat (10) cycle_step();
        chk("t3_no_resp", 32'(resp_cnt[0] + resp_cnt[1]), 32'(r0_before + r1_before));
        mem_compare("t3_mem");

        // 4: write by r0, then read by r1 the following cycle sees new data.
        issue(0, 1'b1, 8'd4, 32'd40);
        issue(1, 1'b0, 8'd4, 32'd0);
        drain();
        chk("t4_rdata", resp_rdata, 32'd40);

        // 5: reset during WAIT of an r0 read.
        cycle_step();
        r0_before = resp_cnt[0];
        issue(0, 1'b0, 8'd7, 32'd0);
        cycle_step();
        chk("t5_in_wait", 32'(dbg_state), 32'(WAIT));
        req_valid = 2'b01;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mode", 32'(mem_mode), 32'd1);
        chk("t5_rst_addr", 32'(mem_addr), 32'd0);
        chk("t5_rst_wdata", mem_data_in, 32'd0);
        chk("t5_rst_resp", 32'(resp_valid), 32'd0);
        chk("t5_rst_rdata", resp_rdata, 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_state", 32'(dbg_state), 32'(IDLE));
        model_reset();
        repeat (3) cycle_step();
        chk("t5_dropped", 32'(resp_cnt[0]), 32'(r0_before));
        req_valid = 2'b00;
        rst_n = 1'b1;
        cycle_step();
        issue(0, 1'b0, 8'd7, 32'd0);
        drain();
        chk("t5_after_rdata", resp_rdata, 32'd22);

        // 6: r1 requests while r0 is busy, then withdraws.
        cycle_step();
        r1_before  = resp_cnt[1];
        hs1_before = grants[1];
        issue(0, 1'b0, 8'd9, 32'd0);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[AW +: AW]  = 8'd10;
        req_wdata[DW +: DW] = 32'hdead_beef;
        repeat (2) cycle_step();
        req_valid[1] = 1'b0;
        drain();
        repeat (2) cycle_step();
        chk("t6_no_r1_resp", 32'(resp_cnt[1]), 32'(r1_before));
        chk("t6_no_r1_grant", 32'(grants[1]), 32'(hs1_before));
        mem_compare("t6_mem");

        // Randomized traffic over a small address window to force reuse.
        for (int n = 0; n < 400; n++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_we    = 2'($urandom_range(0, 3));
            req_addr  = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            req_wdata = {$urandom(), $urandom()};
            cycle_step();
        end
        req_valid = 2'b00;
        drain();
        cycle_step();
        mem_compare("rand_mem");
        chk("rand_activity", 32'(grants[0] > 20 && grants[1] > 5), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
